// File: rtl/counter_2421_pkg.sv
// -----------------------------------------------------------------------------
// counter_2421_pkg
// Shared definitions for the 2421 (Aiken) decade counter.
//   - CODE_0 .. CODE_9 : the ten legal 2421 code words (bit weights 2,4,2,1)
//   - digit_to_code()  : decimal digit 0..9 -> 2421 code (out of range -> 0000)
//   - is_illegal_code(): true for the six unused code words
// -----------------------------------------------------------------------------
package counter_2421_pkg;

  localparam logic [3:0] CODE_0 = 4'b0000;
  localparam logic [3:0] CODE_1 = 4'b0001;
  localparam logic [3:0] CODE_2 = 4'b0010;
  localparam logic [3:0] CODE_3 = 4'b0011;
  localparam logic [3:0] CODE_4 = 4'b0100;
  localparam logic [3:0] CODE_5 = 4'b1011;
  localparam logic [3:0] CODE_6 = 4'b1100;
  localparam logic [3:0] CODE_7 = 4'b1101;
  localparam logic [3:0] CODE_8 = 4'b1110;
  localparam logic [3:0] CODE_9 = 4'b1111;

  localparam logic [3:0] DIGIT_MAX = 4'd9;

  // Decimal digit to 2421 code; anything outside 0..9 maps to the zero code.
  function automatic logic [3:0] digit_to_code(input logic [3:0] digit);
    logic [3:0] code;
    case (digit)
      4'd0:    code = CODE_0;
      4'd1:    code = CODE_1;
      4'd2:    code = CODE_2;
      4'd3:    code = CODE_3;
      4'd4:    code = CODE_4;
      4'd5:    code = CODE_5;
      4'd6:    code = CODE_6;
      4'd7:    code = CODE_7;
      4'd8:    code = CODE_8;
      4'd9:    code = CODE_9;
      default: code = CODE_0;
    endcase
    return code;
  endfunction

  // The six code words the 2421 code never uses.
  function automatic logic is_illegal_code(input logic [3:0] code);
    logic illegal;
    case (code)
      4'b0101, 4'b0110, 4'b0111,
      4'b1000, 4'b1001, 4'b1010: illegal = 1'b1;
      default:                   illegal = 1'b0;
    endcase
    return illegal;
  endfunction

endpackage

// File: rtl/four_bit_2421_counter_if.sv
// -----------------------------------------------------------------------------
// four_bit_2421_counter_if
// Control / data bundle of the 2421 counter.
//   en, up, load, d : driven by the master (testbench / parent)
//   q, tc           : driven by the counter (slave)
//   err             : illegal-load flag, only with FOUR_BIT_2421_ERR_CHECK_EN
// -----------------------------------------------------------------------------
interface four_bit_2421_counter_if;
  logic       en;
  logic       up;
  logic       load;
  logic [3:0] d;
  logic [3:0] q;
  logic       tc;
`ifdef FOUR_BIT_2421_ERR_CHECK_EN
  logic       err;

  modport master (output en, up, load, d, input q, tc, err);
  modport slave  (input en, up, load, d, output q, tc, err);
`else
  modport master (output en, up, load, d, input q, tc);
  modport slave  (input en, up, load, d, output q, tc);
`endif
endinterface

// File: rtl/four_bit_2421_counter_codec.sv
// -----------------------------------------------------------------------------
// aiken_codec
// Combinational conversion between binary digit 0..9 and 2421 code.
//   enc_digit -> enc_code           : encoder
//   dec_code  -> dec_digit, dec_legal : decoder; illegal codes give digit 0
// -----------------------------------------------------------------------------
module aiken_codec
  import counter_2421_pkg::*;
(
  input  logic [3:0] enc_digit,
  output logic [3:0] enc_code,
  input  logic [3:0] dec_code,
  output logic [3:0] dec_digit,
  output logic       dec_legal
);

  // Encoder: digit to code via the shared table.
  always_comb begin
    enc_code = digit_to_code(enc_digit);
  end

  // Decoder: code to digit plus legality flag.
  always_comb begin
    dec_legal = ~is_illegal_code(dec_code);
    case (dec_code)
      CODE_1:  dec_digit = 4'd1;
      CODE_2:  dec_digit = 4'd2;
      CODE_3:  dec_digit = 4'd3;
      CODE_4:  dec_digit = 4'd4;
      CODE_5:  dec_digit = 4'd5;
      CODE_6:  dec_digit = 4'd6;
      CODE_7:  dec_digit = 4'd7;
      CODE_8:  dec_digit = 4'd8;
      CODE_9:  dec_digit = 4'd9;
      default: dec_digit = 4'd0;
    endcase
  end

endmodule

// File: rtl/four_bit_2421_counter.sv
// -----------------------------------------------------------------------------
// four_bit_2421_counter
// Up/down decade counter whose output is in 2421 (Aiken) code.
//   c     : clock, rising edge
//   rst   : asynchronous active-low reset, loads RESET_DIGIT
//   bus   : en/up/load/d in, q (registered 2421 count) / tc out,
//           err out when FOUR_BIT_2421_ERR_CHECK_EN is defined
// Priority per edge: load, then en, else hold. Illegal loads give 0000.
// State is kept as a binary digit; q is registered from the encoded next
// digit so it is a clean flop output and never holds an illegal code.
// -----------------------------------------------------------------------------
module four_bit_2421_counter
  import counter_2421_pkg::*;
#(
  parameter int unsigned RESET_DIGIT = 0
) (
  input  logic                     c,
  input  logic                     rst,
  four_bit_2421_counter_if.slave   bus
);

  // Out-of-range reset digits fall back to zero.
  localparam logic [3:0] RESET_VAL = (RESET_DIGIT <= 9) ? 4'(RESET_DIGIT) : 4'd0;
  localparam logic [3:0] RESET_CODE = digit_to_code(RESET_VAL);

  logic [3:0] digit_r;
  logic [3:0] q_r;
  logic [3:0] next_digit_s;
  logic [3:0] next_code_s;
  logic [3:0] load_digit_s;
  logic       load_legal_s;
  logic       tc_s;

  aiken_codec u_codec (
    .enc_digit (next_digit_s),
    .enc_code  (next_code_s),
    .dec_code  (bus.d),
    .dec_digit (load_digit_s),
    .dec_legal (load_legal_s)
  );

  // Next-digit selection: load, then count with wrap, else hold.
  always_comb begin
    next_digit_s = digit_r;
    if (bus.load) begin
      next_digit_s = load_legal_s ? load_digit_s : 4'd0;
    end else if (bus.en) begin
      if (bus.up) begin
        next_digit_s = (digit_r >= DIGIT_MAX) ? 4'd0 : digit_r + 4'd1;
      end else begin
        next_digit_s = (digit_r == 4'd0) ? DIGIT_MAX : digit_r - 4'd1;
      end
    end else begin
      next_digit_s = digit_r;
    end
  end

  // Counter state and registered 2421 output.
  always_ff @(posedge c or negedge rst) begin
    if (!rst) begin
      digit_r <= RESET_VAL;
      q_r     <= RESET_CODE;
    end else begin
      digit_r <= next_digit_s;
      q_r     <= next_code_s;
    end
  end

  // Terminal count, combinational on the current output code.
  always_comb begin
    tc_s = bus.en & ~bus.load &
           ((bus.up & (q_r == CODE_9)) | (~bus.up & (q_r == CODE_0)));
  end

  assign bus.q  = q_r;
  assign bus.tc = tc_s;

`ifdef FOUR_BIT_2421_ERR_CHECK_EN
  logic err_r;
  logic err_next_s;

  // Illegal-load detection feeding the one-cycle err flag.
  always_comb begin
    err_next_s = bus.load & ~load_legal_s;
  end

  // err is high for the cycle after each illegal load.
  always_ff @(posedge c or negedge rst) begin
    if (!rst) begin
      err_r <= 1'b0;
    end else begin
      err_r <= err_next_s;
    end
  end

  assign bus.err = err_r;
`endif

endmodule

// File: tb/tb_four_bit_2421_counter.sv
// -----------------------------------------------------------------------------
// tb_four_bit_2421_counter
// Directed bench for four_bit_2421_counter with hand-computed expectations.
// err checks are compiled in only with FOUR_BIT_2421_ERR_CHECK_EN.
// -----------------------------------------------------------------------------
module tb_four_bit_2421_counter;

  logic c;
  logic rst;
  int   checks;
  int   errors;

  logic [3:0] codes [10] = '{4'b0000, 4'b0001, 4'b0010, 4'b0011, 4'b0100,
                             4'b1011, 4'b1100, 4'b1101, 4'b1110, 4'b1111};
  logic [3:0] illegal [6] = '{4'b0101, 4'b0110, 4'b0111,
                              4'b1000, 4'b1001, 4'b1010};

  four_bit_2421_counter_if bus_if ();

  four_bit_2421_counter #(.RESET_DIGIT(0)) dut (
    .c   (c),
    .rst (rst),
    .bus (bus_if.slave)
  );

  initial c = 1'b0;
  always #5 c = ~c;

  task automatic check(input string tag, input logic [3:0] observed,
                       input logic [3:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("FAIL %s observed=%b expected=%b", tag, observed, expected);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge c);
    #1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b0;
    bus_if.en = 1'b0;
    bus_if.up = 1'b1;
    bus_if.load = 1'b0;
    bus_if.d = 4'b0000;

    #3;
    check("reset_q", bus_if.q, 4'b0000);
    check("reset_tc", {3'b000, bus_if.tc}, 4'b0000);
`ifdef FOUR_BIT_2421_ERR_CHECK_EN
    check("reset_err", {3'b000, bus_if.err}, 4'b0000);
`endif
    tick();
    tick();
    rst = 1'b1;
    bus_if.en = 1'b1;
    bus_if.up = 1'b1;
    #1;
    check("tc_up_at_0", {3'b000, bus_if.tc}, 4'b0000);

    // Ten up-count edges: 1..9 then wrap to 0.
    for (int k = 1; k <= 10; k++) begin
      tick();
      check($sformatf("up_step%0d", k), bus_if.q, codes[k % 10]);
      if (k == 9) check("tc_up_at_9", {3'b000, bus_if.tc}, 4'b0001);
    end
    check("tc_after_wrap", {3'b000, bus_if.tc}, 4'b0000);

    // Down count from 0 wraps to 9.
    bus_if.up = 1'b0;
    #1;
    check("tc_down_at_0", {3'b000, bus_if.tc}, 4'b0001);
    tick();
    check("down_wrap", bus_if.q, 4'b1111);
    check("tc_down_at_9", {3'b000, bus_if.tc}, 4'b0000);
    tick();
    check("down_8", bus_if.q, 4'b1110);
    tick();
    check("down_7", bus_if.q, 4'b1101);

    // Legal load beats counting; tc masked while loading.
    bus_if.load = 1'b1;
    bus_if.d = 4'b1011;
    bus_if.up = 1'b1;
    #1;
    check("tc_masked_load", {3'b000, bus_if.tc}, 4'b0000);
    tick();
    check("load_legal", bus_if.q, 4'b1011);
`ifdef FOUR_BIT_2421_ERR_CHECK_EN
    check("err_legal", {3'b000, bus_if.err}, 4'b0000);
`endif

    // Illegal load.
    bus_if.d = 4'b0110;
    tick();
    check("load_illegal", bus_if.q, 4'b0000);
`ifdef FOUR_BIT_2421_ERR_CHECK_EN
    check("err_set", {3'b000, bus_if.err}, 4'b0001);
`endif
    bus_if.load = 1'b0;
    bus_if.en = 1'b0;
    tick();
    check("hold_after_illegal", bus_if.q, 4'b0000);
`ifdef FOUR_BIT_2421_ERR_CHECK_EN
    check("err_clear", {3'b000, bus_if.err}, 4'b0000);
`endif

    // Every illegal code gives 0000, each after a legal preload.
    for (int i = 0; i < 6; i++) begin
      bus_if.load = 1'b1;
      bus_if.d = 4'b0011;
      tick();
      bus_if.d = illegal[i];
      tick();
      check($sformatf("illegal_%b", illegal[i]), bus_if.q, 4'b0000);
    end

    // Load with en=0, up=0, then hold for five edges.
    bus_if.load = 1'b1;
    bus_if.en = 1'b0;
    bus_if.up = 1'b0;
    bus_if.d = 4'b1110;
    tick();
    check("load_no_en", bus_if.q, 4'b1110);
    bus_if.load = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      check($sformatf("hold%0d", k), bus_if.q, 4'b1110);
    end

    // Count, then assert reset mid-cycle: q clears before any edge.
    bus_if.en = 1'b1;
    bus_if.up = 1'b1;
    tick();
    check("count_9", bus_if.q, 4'b1111);
    #3;
    rst = 1'b0;
    #1;
    check("async_reset", bus_if.q, 4'b0000);
    tick();
    check("reset_held_edge", bus_if.q, 4'b0000);
    rst = 1'b1;
    tick();
    check("resume_after_reset", bus_if.q, 4'b0001);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/four_bit_2421_counter.md
FOUR_BIT_2421_COUNTER -- requirements
Module: four_bit_2421_counter

Interface
REQ-001 SHALL have parameter RESET_DIGIT, default 0: decimal digit 0..9 loaded on reset, output in 2421 code.
REQ-002 SHALL have port c, input, 1 bit: the only clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port en, input, 1 bit: count enable.
REQ-005 SHALL have port up, input, 1 bit: direction; 1 = count up, 0 = count down.
REQ-006 SHALL have port load, input, 1 bit: synchronous parallel load.
REQ-007 SHALL have port d, input, 4 bits: load value in 2421 code, d[3] weight 2, d[2] weight 4, d[1] weight 2, d[0] weight 1.
REQ-008 SHALL have port q, output, 4 bits: registered count in 2421 (Aiken) code, same bit weights as d.
REQ-009 SHALL have port tc, output, 1 bit: terminal-count / carry-out.
REQ-010 SHALL have port err, output, 1 bit: illegal-load flag; present only when ERR_CHECK_EN is defined.

Function
REQ-011 SHALL use the legal code table: 0=0000, 1=0001, 2=0010, 3=0011, 4=0100, 5=1011, 6=1100, 7=1101, 8=1110, 9=1111.
REQ-012 SHALL treat the six codes 0101, 0110, 0111, 1000, 1001, 1010 as illegal.
REQ-013 SHALL apply priority per rising edge of c: load first, then en, else hold.
REQ-014 SHALL, on load with a legal d, set q to d at the next edge, regardless of en or up.
REQ-015 SHALL, on load with an illegal d, set q to 0000.
REQ-016 SHALL, with en=1, up=1 and load=0, advance q one digit; 9 (1111) wraps to 0 (0000).
REQ-017 SHALL, with en=1, up=0 and load=0, decrement q one digit; 0 (0000) wraps to 9 (1111).
REQ-018 SHALL hold q when en=0 and load=0.
REQ-019 SHALL drive tc combinationally as en & ~load & ((up & q==1111) | (~up & q==0000)).
REQ-020 SHALL update q exactly one clock after the controlling inputs are sampled, with no combinational path from d to q.
REQ-021 SHALL never hold an illegal code in q under any input sequence.

Reset
REQ-022 SHALL, while rst=0, force q to the 2421 code of RESET_DIGIT (0000 by default) and err to 0, immediately and independent of c.
REQ-023 SHALL ignore load and en on the first rising edge of c after rst deasserts only if rst is still low at that edge; otherwise normal operation resumes on that edge.
REQ-024 SHALL, if rst asserts mid-count, abandon the count immediately with no partial update.

Configuration
REQ-025 SHALL, with macro FOUR_BIT_2421_ERR_CHECK_EN defined, register err=1 for exactly one cycle after each edge on which load=1 with an illegal d; otherwise err=0.
REQ-026 SHALL, without FOUR_BIT_2421_ERR_CHECK_EN, omit the err port and its logic; illegal loads still give q=0000.

Structure
REQ-027 SHALL place the ten legal code constants, the decimal-to-2421 table and the illegal-code predicate in shared package counter_2421_pkg.
REQ-028 SHALL keep internal state as a 4-bit binary digit 0..9, with conversion in a single sub-module aiken_codec containing a combinational encoder (digit to 2421) and decoder (2421 to digit plus legal flag).

Verification
REQ-029 SHALL verify: rst=0 -> q=0000, tc=0; rst=1, en=1, up=1 for 10 edges -> q steps 0000, 0001, 0010, 0011, 0100, 1011, 1100, 1101, 1110, 1111, 0000.
REQ-030 SHALL verify: at q=1111 with en=1, up=1 -> tc=1; the next edge gives q=0000 and tc=0.
REQ-031 SHALL verify: q=0000, en=1, up=0 -> tc=1; the next edge gives q=1111, then 1110.
REQ-032 SHALL verify: load=1, d=1011, en=1 -> q=1011 after one edge; load=1, d=0110 -> q=0000 and err=1 for one cycle (macro on).
REQ-033 SHALL verify: en=0 for 5 edges holds q constant; rst pulsed low between edges -> q=0000 immediately.
